aes_key_sched_ctrl: RTL and testbench

- Sequencer for AES-128 key expansion. Produces the 11 round keys (index 0..NR) one at a time on a valid/ready port to the cipher round engine.
- Generates the round-constant sequence internally with GF(2^8) xtime, replacing the table-based round-constant generator.
- Shares one external combinational 4-byte S-box: the block drives its input and consumes its output.

---
 rtl/aes_key_sched_ctrl.sv | 179 +++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: emits round keys 0..NR on a valid/ready port and
// borrows an external combinational S-box for SubWord(RotWord(w3)) during expansion.

module aes_key_sched_ctrl_chk #(
  parameter int unsigned NR = 10
) (
  input logic         clk_i,
  input logic         rst_i,
  input logic         key_ld_i,
  input logic         rk_ready_i,
  input logic         rk_valid_i,
  input logic         busy_i,
  input logic [127:0] rk_out_i,
  input logic [3:0]   rk_idx_i,
  input logic [7:0]   rcon_i
);

  localparam logic [3:0] LastIdx = 4'(NR);

  // A stalled round key must not move until the consumer takes it.
  a_hold_under_backpressure: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (rk_valid_i && !rk_ready_i && !key_ld_i) |=>
      (rk_valid_i && $stable(rk_out_i) && $stable(rk_idx_i) && $stable(rcon_i))
  );

  a_idx_in_range: assert property (@(posedge clk_i) rk_idx_i <= LastIdx);

  a_valid_implies_busy: assert property (@(posedge clk_i) rk_valid_i |-> busy_i);

endmodule

module aes_key_sched_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         key_ld_i,
  input  logic [127:0] key_in_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_out_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_last_o,
  output logic [7:0]   rcon_o,
  output logic         busy_o,
  output logic [31:0]  sb_in_o,
  input  logic [31:0]  sb_out_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  localparam logic [3:0] LastIdx = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] rk,
                                              input logic [31:0]  sub,
                                              input logic [7:0]   rc);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    t  = sub ^ {rc, 24'h000000};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   rk_q, rk_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic [7:0]     rcon_step_s;
  logic           at_last_s;

  assign at_last_s = (idx_q == LastIdx);

  // rcon_q always shows the constant of the key on the port; 01 serves both index 0
  // and the first expansion, so the sequence only advances from index 1 onward.
  assign rcon_step_s = (idx_q == 4'd0) ? rcon_q : xtime(rcon_q);

  // Next-state, next-key and next-rcon selection; key_ld overrides any handshake.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    if (key_ld_i) begin
      state_d = ST_EMIT;
      rk_d    = key_in_i;
      idx_d   = 4'd0;
      rcon_d  = 8'h01;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_EMIT: begin
          if (rk_ready_i) begin
            if (at_last_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_EXPAND;
            end
          end else begin
            state_d = ST_EMIT;
          end
        end
        ST_EXPAND: begin
          if (at_last_s) begin
            state_d = ST_IDLE;
          end else begin
            rk_d    = expand_key(rk_q, sb_out_i, rcon_step_s);
            idx_d   = idx_q + 4'd1;
            rcon_d  = rcon_step_s;
            state_d = ST_EMIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    valid_d = (state_d == ST_EMIT);
    busy_d  = (state_d == ST_EMIT) || (state_d == ST_EXPAND);
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rk_q    <= 128'd0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rk_valid_o = valid_q;
  assign rk_out_o   = rk_q;
  assign rk_idx_o   = idx_q;
  assign rcon_o     = rcon_q;
  assign busy_o     = busy_q;
  assign rk_last_o  = valid_q & at_last_s;
  assign sb_in_o    = {rk_q[23:0], rk_q[31:24]};

  aes_key_sched_ctrl_chk #(.NR(NR)) u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .key_ld_i   (key_ld_i),
    .rk_ready_i (rk_ready_i),
    .rk_valid_i (rk_valid_o),
    .busy_i     (busy_o),
    .rk_out_i   (rk_out_o),
    .rk_idx_i   (rk_idx_o),
    .rcon_i     (rcon_o)
  );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: FIPS-197 schedule, backpressure, reload,
// reset during expansion and a reduced NR=4 instance, with a reference S-box model.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         key_ld_a = 1'b0, key_ld_b = 1'b0;
  logic [127:0] key_in_a = 128'd0, key_in_b = 128'd0;
  logic         ready_a = 1'b0, ready_b = 1'b0;
  logic         valid_a, valid_b, last_a, last_b, busy_a, busy_b;
  logic [127:0] rk_a, rk_b;
  logic [3:0]   idx_a, idx_b;
  logic [7:0]   rcon_a, rcon_b;
  logic [31:0]  sb_in_a, sb_in_b, sb_out_a, sb_out_b;

  int n_checks = 0;
  int n_errors = 0;
  int hs;

  logic [127:0] fips_rk [0:10];
  logic [7:0]   rc_tab  [0:10];
  logic [127:0] fips_key;
  logic [127:0] model;

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int i = 1; i < 256; i++) begin
        if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
      end
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] ref_next(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w [0:7];
    logic [31:0] tmp;
    w[0] = rk[127:96]; w[1] = rk[95:64]; w[2] = rk[63:32]; w[3] = rk[31:0];
    tmp  = sub_word({w[3][23:0], w[3][31:24]}) ^ {rc, 24'h000000};
    w[4] = w[0] ^ tmp;
    for (int i = 5; i < 8; i++) w[i] = w[i-4] ^ w[i-1];
    return {w[4], w[5], w[6], w[7]};
  endfunction

  always_comb sb_out_a = sub_word(sb_in_a);
  always_comb sb_out_b = sub_word(sb_in_b);

  aes_key_sched_ctrl #(.NR(10)) dut_a (
    .clk_i(clk), .rst_i(rst), .key_ld_i(key_ld_a), .key_in_i(key_in_a),
    .rk_valid_o(valid_a), .rk_ready_i(ready_a), .rk_out_o(rk_a), .rk_idx_o(idx_a),
    .rk_last_o(last_a), .rcon_o(rcon_a), .busy_o(busy_a), .sb_in_o(sb_in_a),
    .sb_out_i(sb_out_a)
  );

  aes_key_sched_ctrl #(.NR(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .key_ld_i(key_ld_b), .key_in_i(key_in_b),
    .rk_valid_o(valid_b), .rk_ready_i(ready_b), .rk_out_o(rk_b), .rk_idx_o(idx_b),
    .rk_last_o(last_b), .rcon_o(rcon_b), .busy_o(busy_b), .sb_in_o(sb_in_b),
    .sb_out_i(sb_out_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_emit_a(input int k, input logic [127:0] exp_rk);
    chk($sformatf("a_valid_idx%0d", k), 128'(valid_a), 128'd1);
    chk($sformatf("a_idx_idx%0d", k), 128'(idx_a), 128'(k));
    chk($sformatf("a_rk_idx%0d", k), rk_a, exp_rk);
    chk($sformatf("a_rcon_idx%0d", k), 128'(rcon_a), 128'(rc_tab[k]));
    chk($sformatf("a_last_idx%0d", k), 128'(last_a), 128'(k == 10));
    chk($sformatf("a_busy_idx%0d", k), 128'(busy_a), 128'd1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_valid"}, 128'(valid_a), 128'd0);
    chk({tag, "_rk"},    rk_a,          128'd0);
    chk({tag, "_idx"},   128'(idx_a),   128'd0);
    chk({tag, "_rcon"},  128'(rcon_a),  128'h01);
    chk({tag, "_busy"},  128'(busy_a),  128'd0);
    chk({tag, "_last"},  128'(last_a),  128'd0);
  endtask

  initial begin
    fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[0] = fips_key;
    fips_rk[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2] = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3] = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4] = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6] = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8] = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9] = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rc_tab[0] = 8'h01; rc_tab[1] = 8'h01; rc_tab[2] = 8'h02; rc_tab[3] = 8'h04;
    rc_tab[4] = 8'h08; rc_tab[5] = 8'h10; rc_tab[6] = 8'h20; rc_tab[7] = 8'h40;
    rc_tab[8] = 8'h80; rc_tab[9] = 8'h1b; rc_tab[10] = 8'h36;

    // Reset state
    tick(); tick();
    chk_reset_a("rst");
    chk("rst_b_valid", 128'(valid_b), 128'd0);
    chk("rst_b_busy", 128'(busy_b), 128'd0);
    rst = 1'b0;

    // Full FIPS-197 schedule with rk_ready tied high
    ready_a = 1'b1; key_in_a = fips_key; key_ld_a = 1'b1;
    tick();
    key_ld_a = 1'b0;
    hs = 0;
    for (int c = 0; c < 21; c++) begin
      if (c % 2 == 0) begin
        chk_emit_a(c / 2, fips_rk[c / 2]);
      end else begin
        chk($sformatf("a_gap_valid_c%0d", c), 128'(valid_a), 128'd0);
        chk($sformatf("a_gap_busy_c%0d", c), 128'(busy_a), 128'd1);
      end
      if (valid_a && ready_a) hs++;
      tick();
    end
    chk("a_done_busy", 128'(busy_a), 128'd0);
    chk("a_done_valid", 128'(valid_a), 128'd0);
    chk("a_hs_count", 128'(hs), 128'd11);

    // Backpressure at index 3
    key_ld_a = 1'b1;
    tick();
    key_ld_a = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    ready_a = 1'b0;
    tick();
    for (int c = 0; c < 7; c++) begin
      chk_emit_a(3, fips_rk[3]);
      if (c == 6) ready_a = 1'b1;
      tick();
    end
    chk("bp_release_gap", 128'(valid_a), 128'd0);
    tick();
    chk_emit_a(4, fips_rk[4]);
    tick(); tick();
    chk_emit_a(5, fips_rk[5]);

    // Reload with all-zero key coincident with a handshake at index 5
    key_in_a = 128'd0; key_ld_a = 1'b1;
    tick();
    key_ld_a = 1'b0;
    model = 128'd0;
    for (int k = 0; k <= 10; k++) begin
      chk_emit_a(k, model);
      if (k == 1) chk("zero_rk1_const", rk_a, 128'h62636363626363636263636362636363);
      if (k < 10) model = ref_next(model, rc_tab[k + 1]);
      tick();
      if (k < 10) tick();
    end
    chk("zero_done_busy", 128'(busy_a), 128'd0);

    // Reset asserted during EXPAND
    key_in_a = fips_key; key_ld_a = 1'b1;
    tick();
    key_ld_a = 1'b0;
    tick();
    chk("exp_valid", 128'(valid_a), 128'd0);
    chk("exp_busy", 128'(busy_a), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_a("rst_mid");
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post_rst_valid_c%0d", c), 128'(valid_a), 128'd0);
    end
    key_ld_a = 1'b1;
    tick();
    key_ld_a = 1'b0;
    chk_emit_a(0, fips_key);

    // NR=4 instance
    ready_b = 1'b1; key_in_b = fips_key; key_ld_b = 1'b1;
    tick();
    key_ld_b = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c % 2 == 0) begin
        chk($sformatf("b_valid_c%0d", c), 128'(valid_b), 128'd1);
        chk($sformatf("b_idx_c%0d", c), 128'(idx_b), 128'(c / 2));
        chk($sformatf("b_rk_c%0d", c), rk_b, fips_rk[c / 2]);
        chk($sformatf("b_last_c%0d", c), 128'(last_b), 128'(c == 8));
      end else begin
        chk($sformatf("b_gap_c%0d", c), 128'(valid_b), 128'd0);
      end
      tick();
    end
    chk("b_done_busy", 128'(busy_b), 128'd0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("b_idle_valid_c%0d", c), 128'(valid_b), 128'd0);
      chk($sformatf("b_idle_idx_c%0d", c), 128'(idx_b), 128'd4);
      chk($sformatf("b_idle_last_c%0d", c), 128'(last_b), 128'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
